// File: rtl/nfu_pkg.sv
// Shared constants and state encoding for the NFU-3 sigmoid stage.
// nfu_3 and its controller both read these so table size and latency stay consistent.
package nfu_pkg;

    localparam int BIT_WIDTH     = 16;
    localparam int NUM_SEG       = 16;
    localparam int NFU3_PIPE_LAT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/nfu3_ctrl_valid_pipe.sv
// Fixed-latency 1-bit valid tracker for the NFU-3 datapath.
// o_any reports that at least one beat is still in flight.
module valid_pipe #(
    parameter int PIPE_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_in,
    output logic o_out,
    output logic o_any
);

    logic [PIPE_LAT-1:0] r_stage;

    generate
        if (PIPE_LAT == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (rst) r_stage <= '0;
                else     r_stage <= i_in;
            end
        end else begin : g_multi
            // NOTE: the shift register is reset, unlike a data RAM, because stale
            // valid bits would fire phantom outputs and stall the drain.
            always_ff @(posedge clk) begin
                if (rst) r_stage <= '0;
                else     r_stage <= {r_stage[PIPE_LAT-2:0], i_in};
            end
        end
    endgenerate

    assign o_out = r_stage[PIPE_LAT-1];
    assign o_any = |r_stage;

endmodule

// File: rtl/nfu3_ctrl.sv
// NFU-3 sequencer: streams the sigmoid coefficient table into nfu_3 and gates
// NFU-2 beats into the pipeline only while a complete table is resident.
module nfu3_ctrl
    import nfu_pkg::*;
#(
    parameter int BIT_WIDTH = nfu_pkg::BIT_WIDTH,
    parameter int NUM_SEG   = nfu_pkg::NUM_SEG,
    parameter int ADDR_W    = 4,
    parameter int PIPE_LAT  = nfu_pkg::NFU3_PIPE_LAT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_cfg_start,
    input  logic [2*BIT_WIDTH-1:0] i_coef_data,
    input  logic                   i_coef_valid,
    output logic                   o_coef_ready,
    output logic [2*BIT_WIDTH-1:0] o_coef,
    output logic [ADDR_W-1:0]      o_coef_addr,
    output logic                   o_load_coef,
    input  logic                   i_nfu2_valid,
    output logic                   o_nfu2_ready,
    output logic                   o_nfu3_valid,
    output logic                   o_busy,
    output logic                   o_cfg_done,
    output logic                   o_coef_loaded
);

    generate
        if ((2 ** ADDR_W) < NUM_SEG) begin : g_bad_addr_w
            $error("nfu3_ctrl: ADDR_W too narrow for NUM_SEG");
        end
    endgenerate

    ctrl_state_t            r_state;
    logic [ADDR_W-1:0]      r_cnt;
    logic [2*BIT_WIDTH-1:0] r_coef;
    logic [ADDR_W-1:0]      r_coef_addr;
    logic                   r_load_coef;
    logic                   r_cfg_done;
    logic                   r_coef_loaded;

    logic w_coef_ready;
    logic w_nfu2_ready;
    logic w_accept;
    logic w_coef_hs;
    logic w_last_seg;
    logic w_pipe_any;

    // Handshake readies depend only on registered state, never on the inputs.
    assign w_coef_ready = (r_state == LOAD);
    assign w_nfu2_ready = (r_state == IDLE) && r_coef_loaded;
    assign w_accept     = i_nfu2_valid && w_nfu2_ready;
    assign w_coef_hs    = i_coef_valid && w_coef_ready;
    assign w_last_seg   = (r_cnt == ADDR_W'(NUM_SEG - 1));

    valid_pipe #(
        .PIPE_LAT (PIPE_LAT)
    ) u_valid_pipe (
        .clk   (clk),
        .rst   (rst),
        .i_in  (w_accept),
        .o_out (o_nfu3_valid),
        .o_any (w_pipe_any)
    );

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_coef        <= '0;
            r_coef_addr   <= '0;
            r_load_coef   <= 1'b0;
            r_cfg_done    <= 1'b0;
            r_coef_loaded <= 1'b0;
        end else begin
            r_load_coef <= 1'b0;
            r_cfg_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_cfg_start) begin
                        // A beat accepted this cycle is also in flight.
                        if (w_pipe_any || w_accept) begin
                            r_state <= DRAIN;
                        end else begin
                            r_state       <= LOAD;
                            r_coef_loaded <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (!w_pipe_any) begin
                        r_state       <= LOAD;
                        r_coef_loaded <= 1'b0;
                    end
                end
                LOAD: begin
                    if (w_coef_hs) begin
                        r_coef      <= i_coef_data;
                        r_coef_addr <= r_cnt;
                        r_load_coef <= 1'b1;
                        if (w_last_seg) begin
                            r_cnt      <= '0;
                            r_state    <= DONE;
                            r_cfg_done <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Last write has now reached the RAM; the table is whole.
                    r_coef_loaded <= 1'b1;
                    r_state       <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_coef_ready  = w_coef_ready;
    assign o_nfu2_ready  = w_nfu2_ready;
    assign o_coef        = r_coef;
    assign o_coef_addr   = r_coef_addr;
    assign o_load_coef   = r_load_coef;
    assign o_cfg_done    = r_cfg_done;
    assign o_coef_loaded = r_coef_loaded;
    assign o_busy        = (r_state != IDLE);

endmodule
